// File: rtl/cfg_chain_loader_if.sv
// Word-source bus of the config chain loader: the loader (master) requests a word by
// index and the source (slave) answers with word_valid/word_data.
interface cfg_chain_loader_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 4
) ();
   logic              word_req;
   logic [ADDR_W-1:0] word_addr;
   logic              word_valid;
   logic [WORD_W-1:0] word_data;

   modport master (
      output word_req,
      output word_addr,
      input  word_valid,
      input  word_data
   );

   modport slave (
      input  word_req,
      input  word_addr,
      output word_valid,
      output word_data
   );
endinterface

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: fetches packed config words and shifts them bit-serially into the fabric
// scan chain, then latches it and raises rdy. Optional chain readback/CRC check: CFG_READBACK_EN.
module cfg_chain_loader #(
   parameter int CHAIN_LEN  = 10,
   parameter int WORD_W     = 4,
   parameter int ADDR_W     = 8,
   parameter bit AUTO_START = 1'b1
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               start,
   cfg_chain_loader_if.master wb,
   output logic               cfg_sin,
   output logic               cfg_shift,
   output logic               cfg_latch,
   input  logic               cfg_sout,
   output logic               busy,
   output logic               rdy,
   output logic               cfg_err
);
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int BCNT_W    = $clog2(CHAIN_LEN + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);
   localparam logic [BCNT_W-1:0] WORD_MAX  = BCNT_W'(WORD_W - 1);
   localparam logic [BCNT_W-1:0] LAST_MAX  = BCNT_W'(LAST_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4,
      ST_RDBK  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              last_word;
   logic              word_end;
   logic              load_go;

`ifdef CFG_READBACK_EN
   localparam logic [BCNT_W-1:0] CHAIN_MAX = BCNT_W'(CHAIN_LEN - 1);

   logic        cfg_err_q, cfg_err_d;
   logic [15:0] crc_w_q, crc_w_d;
   logic [15:0] crc_r_q, crc_r_d;

   // CRC-16-CCITT, one bit per call, MSB-first feedback
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb = crc[15] ^ b;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      shreg_q <= shreg_d;
   end

`ifdef CFG_READBACK_EN
   always_ff @(posedge clock) begin
      if (!rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   always_ff @(posedge clock) begin
      crc_w_q <= crc_w_d;
      crc_r_q <= crc_r_d;
   end
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      load_go      = 1'b0;
      wb.word_req  = 1'b0;
      cfg_sin      = 1'b0;
      cfg_shift    = 1'b0;
      cfg_latch    = 1'b0;
`ifdef CFG_READBACK_EN
      cfg_err_d    = cfg_err_q;
      crc_w_d      = crc_w_q;
      crc_r_d      = crc_r_q;
`endif
      last_word    = (addr_q == LAST_ADDR);
      // The last word may carry fewer live bits than WORD_W; its upper bits are dropped.
      word_end     = (bit_cnt_q == (last_word ? LAST_MAX : WORD_MAX));

      unique case (state_q)
         ST_IDLE: begin
            if (AUTO_START || start) load_go = 1'b1;
         end
         ST_FETCH: begin
            wb.word_req = 1'b1;
            if (wb.word_valid) begin
               shreg_d   = wb.word_data;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cfg_shift = 1'b1;
            cfg_sin   = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef CFG_READBACK_EN
            crc_w_d   = crc_step(crc_w_q, shreg_q[0]);
`endif
            if (word_end) begin
               bit_cnt_d = '0;
               if (last_word) begin
                  state_d = ST_LATCH;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_LATCH: begin
            cfg_latch = 1'b1;
            bit_cnt_d = '0;
`ifdef CFG_READBACK_EN
            state_d   = ST_RDBK;
`else
            state_d   = ST_DONE;
`endif
         end
`ifdef CFG_READBACK_EN
         ST_RDBK: begin
            // Recirculate the chain tail into its head so contents survive the readback.
            cfg_shift = 1'b1;
            cfg_sin   = cfg_sout;
            bit_cnt_d = bit_cnt_q + 1'b1;
            crc_r_d   = crc_step(crc_r_q, cfg_sout);
            if (bit_cnt_q == CHAIN_MAX) begin
               bit_cnt_d = '0;
               cfg_err_d = (crc_r_d != crc_w_q);
               state_d   = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            if (start) load_go = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_go) begin
         state_d   = ST_FETCH;
         addr_d    = '0;
         bit_cnt_d = '0;
`ifdef CFG_READBACK_EN
         cfg_err_d = 1'b0;
         crc_w_d   = 16'hFFFF;
         crc_r_d   = 16'hFFFF;
`endif
      end
   end

   assign wb.word_addr = addr_q;
   assign rdy          = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef CFG_READBACK_EN
   assign cfg_err = cfg_err_q;
`else
   logic unused_sout;
   assign unused_sout = cfg_sout;
   assign cfg_err     = 1'b0;
`endif

endmodule
